// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-serial data-memory access controller.
// Byte lanes are numbered 0 (bits 7:0) to 3 (bits 31:24); transfers go MSB lane first.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [2:0] BYTES_BYTE = 3'd1;
  localparam logic [2:0] BYTES_HALF = 3'd2;
  localparam logic [2:0] BYTES_WORD = 3'd4;

  localparam logic [1:0] LANE_MSB_WORD = 2'd3;
  localparam logic [1:0] LANE_MSB_HALF = 2'd1;
  localparam logic [1:0] LANE_MSB_BYTE = 2'd0;

  function automatic logic [2:0] size_bytes(input size_e s);
    case (s)
      SZ_WORD: return BYTES_WORD;
      SZ_HALF: return BYTES_HALF;
      default: return BYTES_BYTE;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input size_e s);
    logic [2:0] n;
    n = size_bytes(s) - 3'd1;
    return n[1:0];
  endfunction

  function automatic logic [1:0] msb_lane(input size_e s);
    case (s)
      SZ_WORD: return LANE_MSB_WORD;
      SZ_HALF: return LANE_MSB_HALF;
      default: return LANE_MSB_BYTE;
    endcase
  endfunction

  // Byte sent at transfer index idx: start at the access's top lane and walk down.
  function automatic logic [7:0] be_lane(input logic [31:0] data, input size_e s,
                                         input logic [1:0] idx);
    logic [1:0]  lane;
    logic [31:0] sh;
    lane = msb_lane(s) - idx;
    sh   = data >> {lane, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/dmem_extend.sv
// Sign/zero extension of an assembled load value to 32 bits.
module dmem_extend
  import dmem_pkg::*;
(
  input  logic [31:0] din,
  input  size_e       size,
  input  logic        z,
  output logic [31:0] dout
);

  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;

  always_comb begin
    b_s  = din[7:0];
    h_s  = din[15:0];
    dout = din;
    case (size)
      SZ_BYTE: dout = z ? {24'h0, din[7:0]}  : 32'(b_s);
      SZ_HALF: dout = z ? {16'h0, din[15:0]} : 32'(h_s);
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store controller that sequences word/half/byte CPU accesses into
// big-endian single-byte cycles on a combinational-read, clocked-write RAM.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic                  w,
  input  logic                  h,
  input  logic                  b,
  input  logic                  z,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic                  done,
  output logic                  addr_error,
  output logic [31:0]           rdata,
  output logic                  ram_ena,
  output logic                  ram_wena,
  output logic [RAM_DEPTH-1:0]  ram_addr,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout
);

  state_e      state;
  size_e       size_q;
  logic        we_q;
  logic        z_q;
  logic [31:0] wdata_q;
  logic [31:0] asm_q;
  logic [1:0]  idx;

  logic        onehot;
  logic        aligned;
  logic        in_range;
  logic        req_ok;
  logic        last;
  size_e       size_in;
  logic [31:0] asm_nx;
  logic [31:0] ext;

  always_comb begin
    onehot   = ({w, h, b} == 3'b100) || ({w, h, b} == 3'b010) || ({w, h, b} == 3'b001);
    aligned  = !(w && (addr[1:0] != 2'b00)) && !(h && addr[0]);
    in_range = ((addr >> RAM_DEPTH) == '0);
    req_ok   = onehot && aligned && in_range;
    size_in  = SZ_BYTE;
    if (w)      size_in = SZ_WORD;
    else if (h) size_in = SZ_HALF;
    asm_nx   = {asm_q[23:0], ram_dout};
    last     = (idx == last_idx(size_q));
  end

  // Extension sees the byte arriving this cycle so rdata is final at the last edge.
  dmem_extend u_extend (
    .din  (asm_nx),
    .size (size_q),
    .z    (z_q),
    .dout (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      addr_error <= 1'b0;
      rdata      <= '0;
      ram_ena    <= 1'b0;
      ram_wena   <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      asm_q      <= '0;
      idx        <= '0;
      size_q     <= SZ_BYTE;
      we_q       <= 1'b0;
      z_q        <= 1'b0;
      wdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            z_q     <= z;
            size_q  <= size_in;
            wdata_q <= wdata;
            idx     <= '0;
            asm_q   <= '0;
            ready   <= 1'b0;
            if (req_ok) begin
              state    <= ST_ACCESS;
              ram_ena  <= 1'b1;
              ram_wena <= we;
              ram_addr <= addr[RAM_DEPTH-1:0];
              ram_din  <= we ? be_lane(wdata, size_in, 2'd0) : 8'h00;
            end else begin
              state      <= ST_RESP;
              done       <= 1'b1;
              addr_error <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (!we_q) asm_q <= asm_nx;
          if (last) begin
            state    <= ST_RESP;
            done     <= 1'b1;
            ram_ena  <= 1'b0;
            ram_wena <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            if (!we_q) rdata <= ext;
          end else begin
            idx      <= idx + 2'd1;
            ram_addr <= ram_addr + RAM_DEPTH'(1);
            ram_din  <= we_q ? be_lane(wdata_q, size_q, idx + 2'd1) : 8'h00;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          done       <= 1'b0;
          addr_error <= 1'b0;
          ready      <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural byte RAM.
module tb_dmem_access_ctrl;

  localparam int AW = 32;
  localparam int RD = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req, we, w, h, b, z;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          ready, done, addr_error;
  logic [31:0]   rdata;
  logic          ram_ena, ram_wena;
  logic [RD-1:0] ram_addr;
  logic [7:0]    ram_din, ram_dout;

  logic [7:0]    mem [0:(1<<RD)-1];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_WIDTH(AW), .RAM_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .w(w), .h(h), .b(b), .z(z),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .addr_error(addr_error),
    .rdata(rdata), .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_ena && ram_wena) mem[ram_addr] <= ram_din;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request from a negedge and observe until done (bounded).
  task automatic xact(input logic iwe, input logic iw, input logic ih, input logic ib,
                      input logic iz, input logic [31:0] iaddr, input logic [31:0] iwd,
                      output int lat, output int ena_n, output int wena_n,
                      output logic err, output logic [31:0] rd);
    int k;
    int c;
    lat = -1; ena_n = 0; wena_n = 0; err = 1'b0; rd = '0;
    k = 0;
    while (!ready && k < 20) begin @(negedge clk); k++; end
    req = 1'b1; we = iwe; w = iw; h = ih; b = ib; z = iz; addr = iaddr; wdata = iwd;
    @(posedge clk);
    #1 req = 1'b0;
    c = 0;
    while (lat < 0 && c < 20) begin
      @(negedge clk);
      c++;
      if (ram_ena) ena_n++;
      if (ram_ena && ram_wena) wena_n++;
      if (done) begin lat = c; err = addr_error; rd = rdata; end
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_back", 32'(ready), 32'd1);
  endtask

  int lat, ena_n, wena_n, dn, first, ena_c;
  logic err;
  logic [31:0] rd;

  initial begin
    for (int i = 0; i < (1 << RD); i++) mem[i] = 8'hAA;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; w = 1'b0; h = 1'b0; b = 1'b0; z = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(addr_error), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ram", {ram_ena, ram_wena, 30'(ram_addr), ram_din}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    xact(1, 1, 0, 0, 0, 32'h010, 32'h12345678, lat, ena_n, wena_n, err, rd);
    check("wst_lat", 32'(lat), 32'd5);
    check("wst_wena", 32'(wena_n), 32'd4);
    check("wst_err", 32'(err), 32'd0);
    check("wst_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'h12345678);

    xact(0, 1, 0, 0, 0, 32'h010, 32'h0, lat, ena_n, wena_n, err, rd);
    check("wld_lat", 32'(lat), 32'd5);
    check("wld_ena", 32'(ena_n), 32'd4);
    check("wld_wena", 32'(wena_n), 32'd0);
    check("wld_rdata", rd, 32'h12345678);

    xact(0, 0, 1, 0, 0, 32'h010, 32'h0, lat, ena_n, wena_n, err, rd);
    check("hld10_lat", 32'(lat), 32'd3);
    check("hld10_rdata", rd, 32'h00001234);
    xact(0, 0, 1, 0, 0, 32'h012, 32'h0, lat, ena_n, wena_n, err, rd);
    check("hld12_rdata", rd, 32'h00005678);

    xact(1, 0, 0, 1, 0, 32'h020, 32'h000000F0, lat, ena_n, wena_n, err, rd);
    check("bst_lat", 32'(lat), 32'd2);
    check("bst_mem", 32'(mem[32]), 32'h0F0);
    check("bst_neighbour", 32'(mem[33]), 32'h0AA);
    xact(0, 0, 0, 1, 0, 32'h020, 32'h0, lat, ena_n, wena_n, err, rd);
    check("bld_sext", rd, 32'hFFFFFFF0);
    xact(0, 0, 0, 1, 1, 32'h020, 32'h0, lat, ena_n, wena_n, err, rd);
    check("bld_zext", rd, 32'h000000F0);

    xact(1, 0, 1, 0, 0, 32'h022, 32'h00008001, lat, ena_n, wena_n, err, rd);
    check("hst_mem", {16'h0, mem[34], mem[35]}, 32'h00008001);
    xact(0, 0, 1, 0, 0, 32'h022, 32'h0, lat, ena_n, wena_n, err, rd);
    check("hld_sext", rd, 32'hFFFF8001);

    xact(0, 1, 0, 0, 0, 32'h011, 32'h0, lat, ena_n, wena_n, err, rd);
    check("bad_w_lat", 32'(lat), 32'd1);
    check("bad_w_err", 32'(err), 32'd1);
    check("bad_w_ena", 32'(ena_n), 32'd0);
    check("bad_w_rdata", rd, 32'hFFFF8001);
    xact(1, 0, 1, 0, 0, 32'h013, 32'h0, lat, ena_n, wena_n, err, rd);
    check("bad_h_err", {lat[7:0], 7'd0, err, 8'(ena_n)}, {8'd1, 7'd0, 1'b1, 8'd0});
    xact(0, 0, 0, 1, 0, 32'h400, 32'h0, lat, ena_n, wena_n, err, rd);
    check("bad_range_err", {lat[7:0], 7'd0, err, 8'(ena_n)}, {8'd1, 7'd0, 1'b1, 8'd0});
    check("bad_range_rdata", rd, 32'hFFFF8001);
    xact(0, 1, 1, 0, 0, 32'h010, 32'h0, lat, ena_n, wena_n, err, rd);
    check("bad_size_err", {lat[7:0], 7'd0, err, 8'(ena_n)}, {8'd1, 7'd0, 1'b1, 8'd0});
    check("bad_size_rdata", rd, 32'hFFFF8001);

    // req held high through a word load: second accepted only once ready returns.
    req = 1'b1; we = 1'b0; w = 1'b1; h = 1'b0; b = 1'b0; z = 1'b0; addr = 32'h010;
    dn = 0; first = -1; ena_c = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin dn++; if (first < 0) first = c; end
      if (ram_ena) ena_c++;
      if (c == 6) check("pulse_ready6", 32'(ready), 32'd1);
      if (c == 7) req = 1'b0;
      if (c == 11) check("pulse_rdata", rdata, 32'h12345678);
    end
    check("pulse_first_done", 32'(first), 32'd5);
    check("pulse_dones", 32'(dn), 32'd2);
    check("pulse_ena", 32'(ena_c), 32'd8);

    // Reset after two bytes of a word store.
    req = 1'b1; we = 1'b1; w = 1'b1; h = 1'b0; b = 1'b0; addr = 32'h030; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_ram", {ram_ena, ram_wena, 30'(ram_addr), ram_din}, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    dn = 0;
    repeat (2) begin @(negedge clk); if (done) dn++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) dn++; end
    check("arst_no_done", 32'(dn), 32'd0);
    check("arst_mem", {mem[48], mem[49], mem[50], mem[51]}, 32'hDEADAAAA);
    check("arst_ready_after", 32'(ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

CPU-side load/store controller that drives the byte-wide data RAM. It accepts one 32-bit word, halfword or byte load/store request from the memory stage and sequences it into 1, 2 or 4 single-byte RAM cycles. Byte order is big-endian. Loads are assembled and then sign- or zero-extended; misaligned and out-of-range accesses are flagged without touching RAM. It sits between the CPU memory stage and the data RAM, which is used in its combinational-read, clocked-write mode.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, CPU address width.
- `RAM_DEPTH`, 10, RAM byte-address bits; RAM holds 2**RAM_DEPTH bytes.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; sampled only while `ready`=1.
- `we`  in  1  1 = store, 0 = load.
- `w`, `h`, `b`  in  1 each  size select (word, half, byte); must be one-hot.
- `z`  in  1  load extension: 1 = zero-extend, 0 = sign-extend; ignored for word loads and for stores.
- `addr`  in  ADDR_WIDTH  byte address.
- `wdata`  in  32  store data, right-justified.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle completion pulse, for loads, stores and errors.
- `addr_error`  out  1  valid with `done`.
- `rdata`  out  32  load result, registered; updated only by a successful load.
- `ram_ena`, `ram_wena`  out  1 each  RAM enable and write enable.
- `ram_addr`  out  RAM_DEPTH  RAM byte address.
- `ram_din`  out  8  RAM write byte.
- `ram_dout`  in  8  RAM read byte, combinational from `ram_addr`.

## Operation
- FSM states:
  - IDLE → ACCESS when the request is accepted and valid.
  - IDLE → RESP when the request is accepted and invalid.
  - ACCESS → RESP after the last byte.
  - RESP → IDLE always.
- Acceptance: `req`=1 and `ready`=1 at a rising edge. The controller latches `we`, size, `z`, `addr` and `wdata`.
- Invalid request, giving `addr_error`=1 and no RAM activity, if any of these holds:
  - size flags are not one-hot;
  - word with `addr[1:0]`≠0;
  - half with `addr[0]`≠0;
  - any of `addr[ADDR_WIDTH-1:RAM_DEPTH]`≠0.
- ACCESS runs N cycles, with N = 4 / 2 / 1 for w / h / b. The byte index `i` counts 0..N-1. Per cycle:
  - `ram_ena`=1;
  - `ram_addr` = latched addr + `i`;
  - `ram_wena` = latched `we`.
- Store byte order, big-endian: word: `i`=0 writes `wdata[31:24]` … `i`=3 writes `wdata[7:0]`. Half: `wdata[15:8]` then `wdata[7:0]`. Byte: `wdata[7:0]`.
- Loads shift `ram_dout` into an assembly register at each ACCESS edge, MSB first. At the final edge `rdata` receives the extended result:
  - byte extends from bit 7;
  - half extends from bit 15;
  - word is passed unchanged.
- RESP asserts `done` for exactly one cycle. `addr_error` is 1 only for invalid requests. `rdata` holds its value until the next successful load completes.
- `req` while `ready`=0 is ignored and not queued.
- All RAM-side outputs are 0 outside ACCESS.

## Timing
- Reset values: state IDLE, `ready`=1. The following are all 0: `done`, `addr_error`, `rdata`, `ram_ena`, `ram_wena`, `ram_addr`, `ram_din`, assembly register and byte index.
- Let acceptance be edge E0. A valid N-byte access drives RAM in cycles E0→E1 … E(N-1)→EN. `done` is high in cycle EN→EN+1. `ready` returns at EN+1.
  - Word: `done` in the 5th cycle after E0; request-to-request spacing is 6 cycles.
  - Byte: spacing is 3 cycles.
- Invalid request: `done`=`addr_error`=1 in cycle E0→E1, `ready` returns at E1. Spacing is 2 cycles.
- RAM writes commit at the edge ending each ACCESS cycle. Load bytes are sampled at that same edge.
- Address increment never wraps in practice: alignment plus the range check keep addr+`i` < 2**RAM_DEPTH.
- Reset mid-operation:
  - aborts immediately to the reset values;
  - bytes already written stay in RAM;
  - no `done` pulse is produced for the aborted request.

## Structure
- Package `dmem_pkg`:
  - state encoding (IDLE, ACCESS, RESP);
  - size codes;
  - byte-count per size;
  - big-endian byte-lane select constants.
- Sub-module `dmem_extend`: combinational sign/zero extension. Inputs: 32-bit assembled data, size, `z`. Output: 32-bit result.
- The FSM, counter, latches and datapath live in `dmem_access_ctrl`.

## Test plan
- Reset, then word store 0x12345678 to 0x010 → RAM[0x010..0x013] = 12,34,56,78; `ram_wena` high 4 cycles; `done` in the 5th cycle after acceptance; `addr_error`=0.
- Word load from 0x010 → `rdata`=0x12345678 with `done`. Half loads from 0x010 and 0x012, `z`=0 → 0x00001234 and 0x00005678.
- Byte store 0xF0 to 0x020. Byte load from 0x020: `z`=0 → 0xFFFFFFF0, `z`=1 → 0x000000F0. Half store 0x8001 to 0x022, then half load with `z`=0 → 0xFFFF8001.
- Each of these → `done`=`addr_error`=1 in the cycle after acceptance, `ram_ena` never high, `rdata` unchanged:
  - word at 0x011;
  - half at 0x013;
  - byte at 0x400 (RAM_DEPTH=10);
  - `w`=`h`=1.
- Pulse `req` every cycle during a word load → only the first request is served and the next is accepted at `ready`. Assert `rst_n`=0 after 2 bytes of a word store to 0x030 → RAM[0x030..0x031] written, RAM[0x032..0x033] untouched, no `done`, all outputs at reset values.
